// File: rtl/cla_seq_adder_if.sv
// Operand/result bundle between a PHA row, the sequential lookahead sum stage,
// and its downstream consumer. The master side drives operands and sinks results.
interface cla_seq_adder_if #(
  parameter int W = 16
);
  logic [W-1:0] pha_s;
  logic [W-1:0] pha_g_n;
  logic [W-1:0] pha_p;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   dbg_state;

  modport master (
    output pha_s, pha_g_n, pha_p, cin, in_valid, out_ready,
    input  in_ready, sum, cout, err, out_valid, dbg_state
  );

  modport slave (
    input  pha_s, pha_g_n, pha_p, cin, in_valid, out_ready,
    output in_ready, sum, cout, err, out_valid, dbg_state
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Sequential carry-lookahead sum stage: resolves one GROUP-bit lookahead block per
// clock from captured PHA (s, g, p) vectors and flags inconsistent PHA inputs.
module cla_seq_adder #(
  parameter int W     = 16,
  parameter int GROUP = 4
) (
  input  logic           clk,
  input  logic           rst,
  cla_seq_adder_if.slave bus
);

  localparam int NG   = W / GROUP;
  localparam int IDXW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      s_q, s_d;
  logic [W-1:0]      g_q, g_d;
  logic [W-1:0]      p_q, p_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;

  logic [GROUP:0]    grp_c;
  logic [GROUP-1:0]  grp_sum;
  logic [W+GROUP-1:0] sum_shift;
  logic              pha_bad;

  // Two-level SOP lookahead: every carry is formed directly from g, p and c0,
  // c(j+1) = g(j) | p(j)g(j-1) | ... | p(j)..p(0)c0, never from a lower carry.
  function automatic logic [GROUP:0] lookahead(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             c0
  );
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int j = 0; j < GROUP; j++) begin
      term = c0;
      for (int m = 0; m <= j; m++) term = term & p[m];
      c[j+1] = term;
      for (int k = 0; k <= j; k++) begin
        term = g[k];
        for (int m = k + 1; m <= j; m++) term = term & p[m];
        c[j+1] = c[j+1] | term;
      end
    end
    return c;
  endfunction

  // Handshakes: a transfer occurs on a rising clk edge where valid and ready are
  // both high. in_ready is only high in IDLE; out_valid is only high in DONE and
  // sum/cout/err stay frozen until the edge where out_ready is also high.
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

  // Any bit with generate but no propagate, generate with a half sum,
  // or a half sum without propagate cannot have come from a real PHA row.
  always_comb begin
    logic [W-1:0] g_in;
    g_in    = ~bus.pha_g_n;
    pha_bad = |((g_in & ~bus.pha_p) | (g_in & bus.pha_s) | (bus.pha_s & ~bus.pha_p));
  end

  always_comb begin
    grp_c     = lookahead(g_q[GROUP-1:0], p_q[GROUP-1:0], carry_q);
    grp_sum   = s_q[GROUP-1:0] ^ grp_c[GROUP-1:0];
    sum_shift = {grp_sum, sum_q};

    state_d     = state_q;
    idx_d       = idx_q;
    s_d         = s_q;
    g_d         = g_q;
    p_d         = p_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.pha_s;
          g_d     = ~bus.pha_g_n;
          p_d     = bus.pha_p;
          carry_d = bus.cin;
          sum_d   = '0;
          idx_d   = '0;
          err_d   = pha_bad;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Operand vectors shift down so the active group is always at bit 0;
        // results enter at the top and reach their final position after NG steps.
        s_d     = s_q >> GROUP;
        g_d     = g_q >> GROUP;
        p_d     = p_q >> GROUP;
        carry_d = grp_c[GROUP];
        sum_d   = sum_shift[W+GROUP-1:GROUP];
        if (idx_q == IDXW'(NG - 1)) begin
          cout_d      = grp_c[GROUP];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      s_q         <= '0;
      g_q         <= '0;
      p_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      g_q         <= g_d;
      p_q         <= p_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifndef SYNTHESIS
  a_result_held : assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(sum_q) && $stable(cout_q) && $stable(err_q)));

  a_valid_only_done : assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q == ST_DONE));
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder at W=8, GROUP=4 (two lookahead cycles per op).
module tb_cla_seq_adder;
  localparam int W     = 8;
  localparam int GROUP = 4;
  localparam int NG    = W / GROUP;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  cla_seq_adder_if #(.W(W)) bus ();

  cla_seq_adder #(.W(W), .GROUP(GROUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] gn,
                        input logic [W-1:0] p, input logic ci,
                        output int lat, output logic [W-1:0] r_sum,
                        output logic r_cout, output logic r_err);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
    end
    bus.pha_s    = s;
    bus.pha_g_n  = gn;
    bus.pha_p    = p;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    r_sum  = bus.sum;
    r_cout = bus.cout;
    r_err  = bus.err;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.pha_s     = '0;
    bus.pha_g_n   = '1;
    bus.pha_p     = '0;
    bus.cin       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL rst_sum got=%h exp=00", bus.sum); end
    n_cmp++; if ({bus.cout, bus.err} !== 2'b00) begin n_fail++; $display("FAIL rst_cout_err got=%b exp=00", {bus.cout, bus.err}); end
    n_cmp++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", bus.dbg_state); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] r; logic c, e;
    // 0x5A + 0x3C = 0x96
    run_op(8'h66, 8'hE7, 8'h7E, 1'b0, lat, r, c, e);
    n_cmp++; if (lat !== NG) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NG); end
    n_cmp++; if (r !== 8'h96) begin n_fail++; $display("FAIL basic_sum got=%h exp=96", r); end
    n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b exp=0", c); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", e); end
    finish_op();
  endtask

  task automatic test_full_ripple();
    int lat; logic [W-1:0] r; logic c, e;
    // 0xFF + 0x01: carry crosses from group 0 into group 1
    run_op(8'hFE, 8'hFE, 8'hFF, 1'b0, lat, r, c, e);
    n_cmp++; if (lat !== NG) begin n_fail++; $display("FAIL ripple_latency got=%0d exp=%0d", lat, NG); end
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL ripple_sum got=%h exp=00", r); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got=%b exp=1", c); end
    finish_op();
  endtask

  task automatic test_cin();
    int lat; logic [W-1:0] r; logic c, e;
    run_op(8'h00, 8'hFF, 8'h00, 1'b1, lat, r, c, e);
    n_cmp++; if (r !== 8'h01) begin n_fail++; $display("FAIL cin_only_sum got=%h exp=01", r); end
    n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL cin_only_cout got=%b exp=0", c); end
    finish_op();
    // 0xFF + 0x00 + 1
    run_op(8'hFF, 8'hFF, 8'hFF, 1'b1, lat, r, c, e);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL cin_wrap_sum got=%h exp=00", r); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL cin_wrap_cout got=%b exp=1", c); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] r; logic c, e;
    // 0x12 + 0x34 = 0x46
    run_op(8'h26, 8'hEF, 8'h36, 1'b0, lat, r, c, e);
    n_cmp++; if (r !== 8'h46) begin n_fail++; $display("FAIL bp_sum got=%h exp=46", r); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      n_cmp++; if (bus.sum !== 8'h46) begin n_fail++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=46", i, bus.sum); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_handoff_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.sum !== 8'h46) begin n_fail++; $display("FAIL bp_sum_kept got=%h exp=46", bus.sum); end
  endtask

  task automatic test_illegal();
    int lat; logic [W-1:0] r; logic c, e;
    // bit 0 has g=1 and s=1; arithmetic still runs: sum=0x03
    run_op(8'h01, 8'hFE, 8'h01, 1'b0, lat, r, c, e);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%b exp=1", e); end
    n_cmp++; if (r !== 8'h03) begin n_fail++; $display("FAIL illegal_sum got=%h exp=03", r); end
    finish_op();
    // 0x5A + 0x3C + 1 = 0x97
    run_op(8'h66, 8'hE7, 8'h7E, 1'b1, lat, r, c, e);
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL legal_after_err got=%b exp=0", e); end
    n_cmp++; if (r !== 8'h97) begin n_fail++; $display("FAIL legal_after_sum got=%h exp=97", r); end
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W-1:0] r; logic c, e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
    end
    bus.pha_s    = 8'h66;
    bus.pha_g_n  = 8'hE7;
    bus.pha_p    = 8'h7E;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL midrst_sum got=%h exp=00", bus.sum); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state got=%0d exp=0", bus.dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_in_ready got=%b exp=1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_valid cyc=%0d got=%b exp=0", i, bus.out_valid); end
    end
    // 0xFF + 0x01 + 1 = 0x101
    run_op(8'hFE, 8'hFE, 8'hFF, 1'b1, lat, r, c, e);
    n_cmp++; if (lat !== NG) begin n_fail++; $display("FAIL midrst_new_latency got=%0d exp=%0d", lat, NG); end
    n_cmp++; if (r !== 8'h01) begin n_fail++; $display("FAIL midrst_new_sum got=%h exp=01", r); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL midrst_new_cout got=%b exp=1", c); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vs [2];
    logic [W-1:0] vg [2];
    logic [W-1:0] vp [2];
    logic [W-1:0] exp_sum [2];
    logic         exp_cout [2];
    int n, got, last_cyc;
    vs[0] = 8'h66; vg[0] = 8'hE7; vp[0] = 8'h7E; exp_sum[0] = 8'h96; exp_cout[0] = 1'b0;
    vs[1] = 8'hFE; vg[1] = 8'hFE; vp[1] = 8'hFF; exp_sum[1] = 8'h00; exp_cout[1] = 1'b1;
    n = 0; got = 0; last_cyc = -1;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (bus.out_valid === 1'b1 && got < 2) begin
        n_cmp++; if (bus.sum !== exp_sum[got]) begin n_fail++; $display("FAIL b2b_sum op=%0d got=%h exp=%h", got, bus.sum, exp_sum[got]); end
        n_cmp++; if (bus.cout !== exp_cout[got]) begin n_fail++; $display("FAIL b2b_cout op=%0d got=%b exp=%b", got, bus.cout, exp_cout[got]); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL b2b_err op=%0d got=%b exp=0", got, bus.err); end
        if (got > 0) begin
          n_cmp++; if (cyc - last_cyc !== NG + 2) begin n_fail++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - last_cyc, NG + 2); end
        end
        last_cyc = cyc;
        got++;
      end
      if (bus.in_ready === 1'b1 && n < 2) begin
        bus.pha_s = vs[n]; bus.pha_g_n = vg[n]; bus.pha_p = vp[n];
        bus.in_valid = 1'b1;
        n++;
      end else if (bus.in_ready === 1'b1) begin
        bus.in_valid = 1'b0;
      end else begin
        // illegal garbage while busy must never be captured
        bus.pha_s = 8'hFF; bus.pha_g_n = 8'h00; bus.pha_p = 8'h00;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (got !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", got); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_full_ripple();
    test_cin();
    test_backpressure();
    test_illegal();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Carry-lookahead sum stage that sits directly downstream of a row of W partial half adders.
- Consumes the per-bit sum (s = a^b), active-low generate (g_n = ~(a&b)) and propagate (p = a|b) vectors.
- Resolves carries one GROUP-bit lookahead block per clock and returns the final W-bit sum and carry-out over a valid/ready handshake.
- Also checks the incoming PHA vectors for self-consistency.

Parameters:
- W, 16, operand width in bits; must be a positive multiple of GROUP.
- GROUP, 4, bits resolved per cycle by the lookahead block.
- NG is derived as W/GROUP, the number of RUN cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pha_s  in  W  per-bit half sum from PHA row
- pha_g_n  in  W  per-bit active-low generate from PHA row
- pha_p  in  W  per-bit propagate from PHA row
- cin  in  1  carry into bit 0
- in_valid  in  1  upstream presents a valid operand set
- in_ready  out  1  block can accept an operand set
- sum  out  W  final sum
- cout  out  1  carry out of bit W-1
- err  out  1  PHA input-consistency violation seen on this operation
- out_valid  out  1  sum/cout/err valid
- out_ready  in  1  downstream accepts result

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high: state=IDLE, sum=0, cout=0, err=0, out_valid=0, idx=0, carry register=0, captured vectors=0.
- in_ready is combinational: it equals (state==IDLE) and is never asserted while rst is high.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1: capture pha_s, g = ~pha_g_n, pha_p and cin; clear sum; set idx=0; compute err; go to RUN.
- RUN:
  - Each cycle processes group k=idx, covering bits [k*GROUP+GROUP-1 : k*GROUP], with c0 = carry register.
  - Lookahead in a single cycle: c(i+1) = g(i) | p(i)&c(i), expanded in two-level sum-of-products form, not rippled through registers.
  - sum bit i = s(i) ^ c(i), registered into sum.
  - The carry register takes the group carry-out.
  - If idx==NG-1: go to DONE and drive cout from the group carry-out. Otherwise idx++.
- DONE:
  - out_valid=1; sum, cout and err are held stable.
  - On a clk edge with out_ready=1: go to IDLE, out_valid=0. sum, cout and err keep their values until the next capture.
- Latency: input accepted at edge 0; out_valid is high after edge NG. Throughput is one operation per NG+2 cycles minimum. There is no bypass: in_ready stays 0 during the DONE→IDLE handoff cycle.
- err: set at capture if any bit violates the PHA invariants:
  - (g=1 and p=0)
  - (g=1 and s=1)
  - (s=1 and p=0)
  - The arithmetic is still performed on the captured values.
- Boundaries:
  - in_valid is ignored outside IDLE, and inputs may change freely then.
  - out_ready is ignored outside DONE.
  - NG=1 is legal: RUN lasts one cycle.
  - A carry out of group k feeds group k+1 on the next cycle.
  - No overflow flag; the result wraps modulo 2^W with cout as the extra bit.
- Reset mid-operation: asserting rst in any state aborts the operation immediately, with outputs as listed above. No result is ever emitted for the aborted operation.

Test Plan:
- W=8, GROUP=4. a=0x5A, b=0x3C → drive s=0x66, g_n=0xE7, p=0x7E, cin=0 → out_valid after 2 RUN edges; sum=0x96, cout=0, err=0.
- Full ripple: s=0xFE, g_n=0xFE, p=0xFF, cin=0 (0xFF+0x01) → sum=0x00, cout=1. The carry crosses the group boundary between cycle 1 and cycle 2.
- cin only: s=0x00, g_n=0xFF, p=0x00, cin=1 → sum=0x01, cout=0. A second op with cin=1 on 0xFF+0x00 (s=0xFF, g_n=0xFF, p=0xFF) → sum=0x00, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum stable, in_ready=0. Raise out_ready → IDLE the next cycle; in_ready=1 one cycle later.
- Illegal input: s=0x01, g_n=0xFE, p=0x01 → err=1 with the result. A following legal op → err=0.
- Reset mid-RUN: assert rst after the first RUN edge → out_valid=0, sum=0, in_ready=1 after release. A new op then produces the correct result and no stale result is ever emitted.
